// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: single-issue execution sequencer for the 8-bit registered ALU.
// Holds an NREG x DW register file, accepts one instruction at a time over a
// valid/ready handshake, drives the ALU for one cycle, then retires the ALU
// result into the register file and its flags into the architectural flags
// register. Direct register loads are accepted only while idle.

module alu_exec_ctrl #(
    parameter int DW   = 8,
    parameter int NREG = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [2:0]               instr_op,
    input  logic [$clog2(NREG)-1:0]  instr_dst,
    input  logic [$clog2(NREG)-1:0]  instr_sa,
    input  logic [$clog2(NREG)-1:0]  instr_sb,
    input  logic                     instr_wb,
    input  logic                     ld_valid,
    input  logic [$clog2(NREG)-1:0]  ld_addr,
    input  logic [DW-1:0]            ld_data,
    input  logic [$clog2(NREG)-1:0]  rd_addr,
    output logic [DW-1:0]            rd_data,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    output logic [2:0]               alu_op,
    input  logic [DW-1:0]            alu_out,
    input  logic [3:0]               alu_flags,
    output logic [3:0]               flags_q,
    output logic                     done
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;

    logic [DW-1:0]   regs_r [NREG];
    logic [3:0]      flags_r;

    // The ALU-facing registers double as the operand/opcode holding registers:
    // they are loaded at accept and keep their value until the next accept so
    // the ALU never sees spurious operand or opcode changes.
    logic [DW-1:0]   alu_a_r;
    logic [DW-1:0]   alu_b_r;
    logic [2:0]      alu_op_r;
    logic [AW-1:0]   dst_h_r;
    logic            wb_h_r;

    logic            instr_ready_s;
    logic            done_s;
    logic            load_s;
    logic            accept_s;
    logic            retire_s;

    // State register with synchronous reset; reset aborts any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> WB -> IDLE unconditionally.
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_WB;
            ST_WB:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output/control decode: loads win over instructions in IDLE, loads elsewhere are dropped.
    always_comb begin
        instr_ready_s = 1'b0;
        done_s        = 1'b0;
        load_s        = 1'b0;
        accept_s      = 1'b0;
        retire_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s        = ld_valid;
                instr_ready_s = ~ld_valid;
                accept_s      = instr_valid & ~ld_valid;
            end
            ST_EXEC: begin
                retire_s = 1'b0;
            end
            ST_WB: begin
                retire_s = 1'b1;
                // A reset arriving in WB aborts the retire, so no done pulse either.
                done_s   = ~rst;
            end
            default: begin
                retire_s = 1'b0;
            end
        endcase
    end

    // Datapath: register file writes, operand capture at accept, flag/result retire in WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
            flags_r  <= 4'b0000;
            alu_a_r  <= {DW{1'b0}};
            alu_b_r  <= {DW{1'b0}};
            alu_op_r <= 3'b000;
            dst_h_r  <= {AW{1'b0}};
            wb_h_r   <= 1'b0;
        end else if (load_s) begin
            regs_r[ld_addr] <= ld_data;
        end else if (accept_s) begin
            // Operand values are sampled now, so dst aliasing a source is harmless.
            alu_a_r  <= regs_r[instr_sa];
            alu_b_r  <= regs_r[instr_sb];
            alu_op_r <= instr_op;
            dst_h_r  <= instr_dst;
            wb_h_r   <= instr_wb;
        end else if (retire_s) begin
            flags_r <= alu_flags;
            if (wb_h_r) begin
                regs_r[dst_h_r] <= alu_out;
            end
        end
    end

    assign rd_data     = regs_r[rd_addr];
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_op      = alu_op_r;
    assign flags_q     = flags_r;
    assign instr_ready = instr_ready_s;
    assign done        = done_s;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Testbench for alu_exec_ctrl. Includes a behavioural stand-in for the 8-bit
// registered ALU (result registered, C/O derived from the live opcode), a
// table of directed instruction vectors and hand-written corner sequences.

module tb_alu_exec_ctrl;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [2:0] instr_dst;
    logic [2:0] instr_sa;
    logic [2:0] instr_sb;
    logic       instr_wb;
    logic       ld_valid;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_out;
    logic [3:0] alu_flags;
    logic [3:0] flags_q;
    logic       done;

    int errors = 0;
    int checks = 0;

    alu_exec_ctrl #(.DW(8), .NREG(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_dst   (instr_dst),
        .instr_sa    (instr_sa),
        .instr_sb    (instr_sb),
        .instr_wb    (instr_wb),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags),
        .flags_q     (flags_q),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU stand-in (no reset, one-cycle registered result) ----
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [7:0] m_out;

    function automatic logic [7:0] alu_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            3'd3:    return a & b;
            3'd4:    return (a == 8'h00) ? 8'h01 : 8'h00;
            3'd5:    return (a == b) ? 8'h01 : 8'h00;
            3'd6:    return a >> 1;
            default: return a << 1;
        endcase
    endfunction

    // ALU result/operand registers
    always @(posedge clk) begin
        m_a   <= alu_a;
        m_b   <= alu_b;
        m_out <= alu_res(alu_op, alu_a, alu_b);
    end

    // ALU flags: C and O depend on the live opcode
    always_comb begin
        logic [8:0] sum9;
        logic       c_f;
        logic       o_f;
        sum9 = {1'b0, m_a} + {1'b0, m_b};
        c_f  = 1'b0;
        o_f  = 1'b0;
        if (alu_op == 3'd0) begin
            c_f = sum9[8];
            o_f = (m_a[7] == m_b[7]) && (m_out[7] != m_a[7]);
        end else if (alu_op == 3'd1) begin
            c_f = (m_a < m_b);
            o_f = (m_a[7] != m_b[7]) && (m_out[7] != m_a[7]);
        end
        alu_flags = {c_f, m_out[7], o_f, (m_out == 8'h00)};
        alu_out   = m_out;
    end

    // ---------------- checking helpers ----------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called and returns at a negedge; the load is captured at the posedge in between.
    task automatic do_load(input logic [2:0] a, input logic [7:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    // Called and returns at a negedge in IDLE; checks handshake, ALU drive, retire.
    task automatic issue(input string nm, input logic [2:0] op, input logic [2:0] dst,
                         input logic [2:0] sa, input logic [2:0] sb, input logic wb,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic [7:0] ev, input logic [3:0] ef);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_dst   = dst;
        instr_sa    = sa;
        instr_sb    = sb;
        instr_wb    = wb;
        rd_addr     = dst;
        #1;
        chk({nm, "_ready_offer"}, 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk({nm, "_exec_done"}, 32'(done), 32'd0);
        chk({nm, "_exec_a"}, 32'(alu_a), 32'(ea));
        chk({nm, "_exec_b"}, 32'(alu_b), 32'(eb));
        chk({nm, "_exec_op"}, 32'(alu_op), 32'(op));
        @(negedge clk);
        chk({nm, "_wb_done"}, 32'(done), 32'd1);
        chk({nm, "_wb_op"}, 32'(alu_op), 32'(op));
        chk({nm, "_wb_ready"}, 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk({nm, "_val"}, 32'(rd_data), 32'(ev));
        chk({nm, "_flags"}, 32'(flags_q), 32'(ef));
        chk({nm, "_idle_done"}, 32'(done), 32'd0);
        chk({nm, "_idle_ready"}, 32'(instr_ready), 32'd1);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [2:0] dst;
        logic [2:0] sa;
        logic [2:0] sb;
        logic       wb;
        logic [7:0] pa;
        logic [7:0] pb;
        logic [7:0] ev;
        logic [3:0] ef;
    } vec_t;

    vec_t vecs [8];

    // Watchdog: the test is fixed-length, so this only fires on a broken bench/run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          op    dst   sa    sb    wb    pa     pb     ev     ef
        vecs[0] = '{3'd0, 3'd3, 3'd1, 3'd2, 1'b1, 8'h7F, 8'h01, 8'h80, 4'b0110}; // add overflow
        vecs[1] = '{3'd1, 3'd4, 3'd1, 3'd2, 1'b1, 8'h01, 8'h02, 8'hFF, 4'b1100}; // sub borrow
        vecs[2] = '{3'd5, 3'd7, 3'd5, 3'd6, 1'b0, 8'h01, 8'h01, 8'h00, 4'b0000}; // comp, flags only
        vecs[3] = '{3'd4, 3'd6, 3'd5, 3'd6, 1'b1, 8'h01, 8'h01, 8'h00, 4'b0001}; // not -> zero
        vecs[4] = '{3'd2, 3'd2, 3'd1, 3'd2, 1'b1, 8'hA0, 8'h05, 8'hA5, 4'b0100}; // or, dst==sb
        vecs[5] = '{3'd3, 3'd0, 3'd1, 3'd2, 1'b1, 8'hF0, 8'h0F, 8'h00, 4'b0001}; // and -> zero
        vecs[6] = '{3'd0, 3'd1, 3'd1, 3'd2, 1'b1, 8'hFF, 8'h01, 8'h00, 4'b1001}; // add carry, dst==sa
        vecs[7] = '{3'd1, 3'd5, 3'd3, 3'd4, 1'b1, 8'h80, 8'h01, 8'h7F, 4'b0010}; // sub overflow

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_op    = 3'd0;
        instr_dst   = 3'd0;
        instr_sa    = 3'd0;
        instr_sb    = 3'd0;
        instr_wb    = 1'b0;
        ld_valid    = 1'b0;
        ld_addr     = 3'd0;
        ld_data     = 8'h00;
        rd_addr     = 3'd0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'(flags_q), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r);
            #1;
            chk($sformatf("rst_reg%0d", r), 32'(rd_data), 32'd0);
        end
        @(negedge clk);

        // ---- table-driven instructions ----
        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].sa, vecs[i].pa);
            do_load(vecs[i].sb, vecs[i].pb);
            issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb,
                  vecs[i].wb, vecs[i].pa, vecs[i].pb, vecs[i].ev, vecs[i].ef);
        end

        // ---- load and instruction together: load wins, instruction waits ----
        ld_valid    = 1'b1;
        ld_addr     = 3'd2;
        ld_data     = 8'h33;
        instr_valid = 1'b1;
        instr_op    = 3'd2;
        instr_dst   = 3'd3;
        instr_sa    = 3'd2;
        instr_sb    = 3'd2;
        instr_wb    = 1'b1;
        #1;
        chk("coll_ready_low", 32'(instr_ready), 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        rd_addr  = 3'd2;
        #1;
        chk("coll_load_done", 32'(rd_data), 32'h33);
        chk("coll_ready_high", 32'(instr_ready), 32'd1);
        @(negedge clk);
        // now in EXEC: this load must be dropped
        instr_valid = 1'b0;
        chk("coll_exec_a", 32'(alu_a), 32'h33);
        ld_valid = 1'b1;
        ld_addr  = 3'd4;
        ld_data  = 8'h5A;
        @(negedge clk);
        ld_valid = 1'b0;
        chk("coll_wb_done", 32'(done), 32'd1);
        @(negedge clk);
        rd_addr = 3'd3;
        #1;
        chk("coll_result", 32'(rd_data), 32'h33);
        rd_addr = 3'd4;
        #1;
        chk("exec_load_dropped", 32'(rd_data), 32'h01);

        // ---- back-to-back dependent shifts ----
        do_load(3'd1, 8'h81);
        issue("shl", 3'd7, 3'd1, 3'd1, 3'd1, 1'b1, 8'h81, 8'h81, 8'h02, 4'b0000);
        issue("shr", 3'd6, 3'd1, 3'd1, 3'd1, 1'b1, 8'h02, 8'h02, 8'h01, 4'b0000);

        // ---- reset during WB aborts the instruction ----
        do_load(3'd1, 8'h7F);
        do_load(3'd2, 8'h01);
        issue("pre_rst_add", 3'd0, 3'd5, 3'd1, 3'd2, 1'b1, 8'h7F, 8'h01, 8'h80, 4'b0110);
        instr_valid = 1'b1;
        instr_op    = 3'd0;
        instr_dst   = 3'd3;
        instr_sa    = 3'd1;
        instr_sb    = 3'd2;
        instr_wb    = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstwb_no_done", 32'(done), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        rd_addr = 3'd3;
        #1;
        chk("rstwb_ready", 32'(instr_ready), 32'd1);
        chk("rstwb_done", 32'(done), 32'd0);
        chk("rstwb_flags", 32'(flags_q), 32'd0);
        chk("rstwb_dst", 32'(rd_data), 32'd0);
        rd_addr = 3'd5;
        #1;
        chk("rstwb_r5", 32'(rd_data), 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
